border_mask_sequencer: RTL and testbench

Frame-buffered border-masking stage for the skeletonization/corner pipeline. It accepts one WIDTH x HEIGHT frame of pixels, each with a per-pixel corner flag, over a valid/ready stream into internal storage. It then replays the frame in raster order with the BORDER-wide outer ring substituted according to a selectable pad mode. It generalises the fixed N x N, 1-pixel, zero-only center mask to rectangular frames, any border width, three pad modes and full backpressure.

---
 rtl/border_mask_if.sv | 30 +++
 rtl/border_mask_sequencer.sv | 175 +++++++++++++++++
 tb/tb_border_mask_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/border_mask_if.sv
// Stream and configuration bundle for border_mask_sequencer: pixel input stream,
// pad configuration, masked pixel output stream and busy status.
interface border_mask_if #(
   parameter int PIXEL_W = 8,
   parameter int ADDR_W  = 6
);
   logic               in_valid;
   logic               in_ready;
   logic [PIXEL_W-1:0] in_data;
   logic               in_flag;
   logic [1:0]         pad_mode;
   logic [PIXEL_W-1:0] pad_value;
   logic               out_valid;
   logic               out_ready;
   logic [PIXEL_W-1:0] out_data;
   logic               out_flag;
   logic [ADDR_W-1:0]  out_addr;
   logic               out_last;
   logic               busy;

   modport master (
      output in_valid, in_data, in_flag, pad_mode, pad_value, out_ready,
      input  in_ready, out_valid, out_data, out_flag, out_addr, out_last, busy
   );

   modport slave (
      input  in_valid, in_data, in_flag, pad_mode, pad_value, out_ready,
      output in_ready, out_valid, out_data, out_flag, out_addr, out_last, busy
   );
endinterface

// File: rtl/border_mask_sequencer.sv
// Buffers one WIDTH x HEIGHT frame, then replays it in raster order with the outer
// BORDER ring zeroed, replicated or filled. Define FLAG_COUNT_EN to add flag_count.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_LOAD  | accepting pixels into the frame store, in_ready high
//   S_DRAIN | replaying the masked frame through the output register, busy high
module border_mask_sequencer #(
   parameter  int WIDTH   = 8,
   parameter  int HEIGHT  = 8,
   parameter  int PIXEL_W = 8,
   parameter  int BORDER  = 1,
   localparam int ADDR_W  = $clog2(WIDTH*HEIGHT)
) (
   input logic          clk,
   input logic          rst_n,
   border_mask_if.slave bus
`ifdef FLAG_COUNT_EN
   ,
   output logic [ADDR_W:0] flag_count
`endif
);
   localparam int NPIX  = WIDTH*HEIGHT;
   localparam int ROW_W = $clog2(HEIGHT);
   localparam int COL_W = $clog2(WIDTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX-1);

   generate
      if (!((2*BORDER < WIDTH) && (2*BORDER < HEIGHT))) begin : g_bad_border
         $error("border_mask_sequencer: BORDER too large for frame");
      end
   endgenerate

   typedef enum logic {S_LOAD, S_DRAIN} state_t;

   state_t              r_state, w_next_state;
   logic [PIXEL_W:0]    r_mem [NPIX];
   logic [ADDR_W-1:0]   r_wr_addr, r_rd_addr;
   logic [ROW_W-1:0]    r_row;
   logic [COL_W-1:0]    r_col;
   logic [1:0]          r_mode;
   logic [PIXEL_W-1:0]  r_pad;
   logic                r_primed;
   logic                r_out_valid, r_out_flag, r_out_last;
   logic [PIXEL_W-1:0]  r_out_data;
   logic [ADDR_W-1:0]   r_out_addr;

   logic                w_in_ready, w_busy;
   logic                w_wr_fire, w_wr_last, w_out_fire, w_last_acc, w_load;
   logic                w_border, w_nxt_flag;
   logic [ADDR_W-1:0]   w_src_addr;
   logic [PIXEL_W:0]    w_cur, w_src;
   logic [PIXEL_W-1:0]  w_nxt_data;

   assign w_wr_fire  = bus.in_valid && w_in_ready;
   assign w_wr_last  = (r_wr_addr == LAST_ADDR);
   assign w_out_fire = r_out_valid && bus.out_ready;
   assign w_last_acc = w_out_fire && r_out_last;
   // r_primed inserts the one-cycle bubble between frame capture and first beat
   assign w_load     = (r_state == S_DRAIN) && r_primed && (!r_out_valid || bus.out_ready)
                       && !w_last_acc;

   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      w_busy       = 1'b0;
      case (r_state)
         S_LOAD: begin
            w_in_ready = 1'b1;
            if (w_wr_fire && w_wr_last) w_next_state = S_DRAIN;
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (w_last_acc) w_next_state = S_LOAD;
         end
      endcase
   end

   always_comb begin
      int row, col, srow, scol;
      row  = int'(r_row);
      col  = int'(r_col);
      w_border = (row < BORDER) || (row >= HEIGHT-BORDER) ||
                 (col < BORDER) || (col >= WIDTH-BORDER);
      srow = (row < BORDER) ? BORDER : ((row > HEIGHT-1-BORDER) ? HEIGHT-1-BORDER : row);
      scol = (col < BORDER) ? BORDER : ((col > WIDTH-1-BORDER)  ? WIDTH-1-BORDER  : col);
      w_src_addr = ADDR_W'(srow*WIDTH + scol);
      w_cur      = r_mem[r_rd_addr];
      w_src      = r_mem[w_src_addr];
      w_nxt_data = w_cur[PIXEL_W-1:0];
      w_nxt_flag = w_cur[PIXEL_W];
      if (w_border) begin
         w_nxt_flag = 1'b0;
         case (r_mode)
            2'd1:    w_nxt_data = w_src[PIXEL_W-1:0];
            2'd2:    w_nxt_data = r_pad;
            default: w_nxt_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_fire) r_mem[r_wr_addr] <= {bus.in_flag, bus.in_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_LOAD;
         r_wr_addr   <= '0;
         r_rd_addr   <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_mode      <= '0;
         r_pad       <= '0;
         r_primed    <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_flag  <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_out_addr  <= '0;
      end else begin
         r_state  <= w_next_state;
         r_primed <= (r_state == S_DRAIN) && !w_last_acc;
         if (w_wr_fire) begin
            if (w_wr_last) begin
               r_wr_addr <= '0;
               r_mode    <= bus.pad_mode;
               r_pad     <= bus.pad_value;
            end else begin
               r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
         end
         if (w_last_acc) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_rd_addr   <= '0;
            r_row       <= '0;
            r_col       <= '0;
         end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_nxt_data;
            r_out_flag  <= w_nxt_flag;
            r_out_addr  <= r_rd_addr;
            r_out_last  <= (r_rd_addr == LAST_ADDR);
            if (r_rd_addr != LAST_ADDR) begin
               r_rd_addr <= r_rd_addr + ADDR_W'(1);
               if (r_col == COL_W'(WIDTH-1)) begin
                  r_col <= '0;
                  r_row <= r_row + ROW_W'(1);
               end else begin
                  r_col <= r_col + COL_W'(1);
               end
            end
         end
      end
   end

`ifdef FLAG_COUNT_EN
   logic [ADDR_W:0] r_flag_count;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       r_flag_count <= '0;
      else if (w_wr_fire && w_wr_last)  r_flag_count <= '0;
      else if (w_out_fire && r_out_flag) r_flag_count <= r_flag_count + (ADDR_W+1)'(1);
   end
   assign flag_count = r_flag_count;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.busy      = w_busy;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_flag  = r_out_flag;
   assign bus.out_addr  = r_out_addr;
   assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_border_mask_sequencer.sv
// Directed bench for border_mask_sequencer: 4x4/B=1 and 6x5/B=2 instances, all pad
// modes, backpressure, mid-frame reset and the bubble latency.
module tb_border_mask_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       sel, drv_valid, drv_flag, drv_ready;
   logic [7:0] drv_data, pad_value;
   logic [1:0] pad_mode;
   int         n_tests = 0, n_fail = 0;

   border_mask_if #(.PIXEL_W(8), .ADDR_W(4)) ifa ();
   border_mask_if #(.PIXEL_W(8), .ADDR_W(5)) ifb ();

   assign ifa.in_valid  = drv_valid & ~sel;
   assign ifb.in_valid  = drv_valid & sel;
   assign ifa.in_data   = drv_data;   assign ifb.in_data   = drv_data;
   assign ifa.in_flag   = drv_flag;   assign ifb.in_flag   = drv_flag;
   assign ifa.pad_mode  = pad_mode;   assign ifb.pad_mode  = pad_mode;
   assign ifa.pad_value = pad_value;  assign ifb.pad_value = pad_value;
   assign ifa.out_ready = drv_ready;  assign ifb.out_ready = drv_ready;

`ifdef FLAG_COUNT_EN
   logic [4:0] fc_a;
   logic [5:0] fc_b;
`endif

   border_mask_sequencer #(.WIDTH(4), .HEIGHT(4), .PIXEL_W(8), .BORDER(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
`ifdef FLAG_COUNT_EN
      , .flag_count(fc_a)
`endif
   );
   border_mask_sequencer #(.WIDTH(6), .HEIGHT(5), .PIXEL_W(8), .BORDER(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
`ifdef FLAG_COUNT_EN
      , .flag_count(fc_b)
`endif
   );

   logic       obs_valid, obs_flag, obs_last, obs_in_ready, obs_busy;
   logic [7:0] obs_data, obs_addr;
   always_comb begin
      obs_valid = sel ? ifb.out_valid : ifa.out_valid;
      obs_flag  = sel ? ifb.out_flag  : ifa.out_flag;
      obs_last  = sel ? ifb.out_last  : ifa.out_last;
      obs_data  = sel ? ifb.out_data  : ifa.out_data;
      obs_addr  = sel ? 8'(ifb.out_addr) : 8'(ifa.out_addr);
      obs_in_ready = sel ? ifb.in_ready : ifa.in_ready;
      obs_busy  = sel ? ifb.busy : ifa.busy;
   end

   int zero4[16]  = '{0,0,0,0, 0,6,7,0, 0,10,11,0, 0,0,0,0};
   int rep4[16]   = '{6,6,7,7, 6,6,7,7, 10,10,11,11, 10,10,11,11};
   int const4[16] = '{8'hAA,8'hAA,8'hAA,8'hAA, 8'hAA,6,7,8'hAA,
                      8'hAA,10,11,8'hAA, 8'hAA,8'hAA,8'hAA,8'hAA};
   int         exp_d[32];
   logic       exp_f[32];
   logic [7:0] got_d[32], got_a[32];
   logic       got_f[32], got_l[32];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input int n, input int base, input logic [31:0] flags);
      for (int i = 0; i < n; i++) begin
         int w;
         drv_valid = 1'b1;
         drv_data  = 8'(base + i);
         drv_flag  = flags[i];
         w = 0;
         while (!obs_in_ready && w < 50) begin
            @(posedge clk); #1; w++;
         end
         if (w >= 50) check("in_ready_timeout", 32'(w), 0);
         @(posedge clk); #1;
      end
      drv_valid = 1'b0;
      drv_flag  = 1'b0;
   endtask

   task automatic run_drain(input int n, input int stall_addr, input string tag,
                            output int first_idx);
      int got, cyc, stall, held;
      got = 0; cyc = 0; stall = 0; held = 0; first_idx = -1;
      while (got < n && cyc < 400) begin
         if (obs_valid && first_idx < 0) first_idx = cyc;
         drv_ready = 1'b1;
         if (obs_valid && int'(obs_addr) == stall_addr) begin
            held++;
            check($sformatf("%s_held_data", tag), 32'(obs_data), 32'(exp_d[stall_addr]));
            if (stall < 3) begin
               drv_ready = 1'b0;
               stall++;
            end
         end
         if (obs_valid && drv_ready) begin
            got_d[got] = obs_data; got_a[got] = obs_addr;
            got_f[got] = obs_flag; got_l[got] = obs_last;
            got++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      drv_ready = 1'b1;
      check($sformatf("%s_beats", tag), 32'(got), 32'(n));
      if (stall_addr >= 0) check($sformatf("%s_held_cycles", tag), 32'(held), 4);
   endtask

   task automatic do_frame(input int n, input logic [31:0] flags, input int stall_addr,
                           input logic [1:0] m1, input logic [7:0] p1,
                           input logic [1:0] m2, input logic [7:0] p2, input string tag);
      int first, nflag;
      pad_mode = m1; pad_value = p1;
      send_frame(n, 1, flags);
      pad_mode = m2; pad_value = p2;
      check($sformatf("%s_busy", tag), 32'(obs_busy), 1);
      check($sformatf("%s_in_ready_drain", tag), 32'(obs_in_ready), 0);
      run_drain(n, stall_addr, tag, first);
      check($sformatf("%s_first_valid_idx", tag), 32'(first), 2);
      nflag = 0;
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_data[%0d]", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
         check($sformatf("%s_addr[%0d]", tag, i), 32'(got_a[i]), 32'(i));
         check($sformatf("%s_flag[%0d]", tag, i), 32'(got_f[i]), 32'(exp_f[i]));
         check($sformatf("%s_last[%0d]", tag, i), 32'(got_l[i]), 32'(i == n-1));
         if (exp_f[i]) nflag++;
      end
      check($sformatf("%s_valid_after", tag), 32'(obs_valid), 0);
      check($sformatf("%s_in_ready_after", tag), 32'(obs_in_ready), 1);
`ifdef FLAG_COUNT_EN
      check($sformatf("%s_flag_count", tag), sel ? 32'(fc_b) : 32'(fc_a), 32'(nflag));
`endif
   endtask

   initial begin
      sel = 1'b0; drv_valid = 1'b0; drv_flag = 1'b0; drv_data = '0;
      drv_ready = 1'b1; pad_mode = '0; pad_value = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready_a",  32'(ifa.in_ready), 1);
      check("rst_out_valid_a", 32'(ifa.out_valid), 0);
      check("rst_busy_a",      32'(ifa.busy), 0);
      check("rst_out_last_a",  32'(ifa.out_last), 0);
      check("rst_out_data_a",  32'(ifa.out_data), 0);
      check("rst_out_addr_a",  32'(ifa.out_addr), 0);
      check("rst_in_ready_b",  32'(ifb.in_ready), 1);
      check("rst_out_valid_b", 32'(ifb.out_valid), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 32; i++) begin exp_d[i] = 0; exp_f[i] = 1'b0; end
      for (int i = 0; i < 16; i++) exp_d[i] = zero4[i];
      do_frame(16, 32'h0, -1, 2'd0, 8'h00, 2'd0, 8'h00, "zero");

      for (int i = 0; i < 16; i++) exp_d[i] = rep4[i];
      exp_f[5] = 1'b1;
      do_frame(16, 32'h21, -1, 2'd1, 8'h00, 2'd1, 8'h00, "replicate");
      exp_f[5] = 1'b0;

      for (int i = 0; i < 16; i++) exp_d[i] = const4[i];
      do_frame(16, 32'h0, 5, 2'd2, 8'hAA, 2'd0, 8'h55, "const_bp");

      send_frame(7, 8'h50, 32'hFFFF_FFFF);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready",  32'(ifa.in_ready), 1);
      check("abort_out_valid", 32'(ifa.out_valid), 0);
      check("abort_busy",      32'(ifa.busy), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) exp_d[i] = zero4[i];
      do_frame(16, 32'h0, -1, 2'd0, 8'h00, 2'd0, 8'h00, "post_abort");

      sel = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 32; i++) exp_d[i] = 0;
      exp_d[14] = 15;
      exp_d[15] = 16;
      do_frame(30, 32'h0, -1, 2'd0, 8'h00, 2'd0, 8'h00, "b6x5");
      sel = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
